// File: rtl/mod_pkg.sv
// mod_pkg: definitions shared by the modular-arithmetic blocks (mod_inv,
// MM, long_div) and the controller that sequences them.
//   MOD_WIDTH : default operand width in bits
//   mod_state_e : IDLE / ITER / FIN sequencing states
package mod_pkg;

  localparam int unsigned MOD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } mod_state_e;

endpackage

// File: rtl/mod_sub.sv
// mod_sub: combinational modular subtraction, diff = (a - b) mod n.
// Both a and b are expected in [0, n-1]; the result is then also in [0, n-1].
// Ports:
//   a, b  in  WIDTH  operands
//   n     in  WIDTH  modulus
//   diff  out WIDTH  (a - b) mod n
module mod_sub
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] diff
);

  logic [WIDTH:0] a_x;
  logic [WIDTH:0] b_x;
  logic [WIDTH:0] n_x;
  logic [WIDTH:0] sum;

  always_comb begin
    a_x = {1'b0, a};
    b_x = {1'b0, b};
    n_x = {1'b0, n};
    // a + n can exceed 2^WIDTH when n is close to the top of the range, so
    // the wrap-around correction is formed one bit wider than the operands.
    if (a >= b) begin
      sum = a_x - b_x;
    end else begin
      sum = a_x + n_x - b_x;
    end
    diff = WIDTH'(sum);
  end

endmodule

// File: rtl/mod_inv.sv
// mod_inv: sequential modular inverse, out = A^-1 mod N (N odd), using the
// binary extended Euclidean algorithm with one reduction step per clock.
// Invariants while iterating: x1*A == u (mod N), x2*A == v (mod N).
// Ports:
//   clk    in  1      rising-edge clock
//   rstn   in  1      synchronous active-low reset
//   start  in  1      launch request, honoured only while busy=0
//   A      in  WIDTH  value to invert, sampled with start
//   N      in  WIDTH  modulus (odd), sampled with start
//   busy   out 1      operation in progress
//   done   out 1      one-cycle completion pulse
//   ok     out 1      1: inverse exists and out is valid (held after done)
//   out    out WIDTH  result, held until a later operation completes
// Build option: define MOD_INV_ARGCHK_EN to reject illegal operands on start
// (N even, N<3, A==0, A>=N); rejected operations finish with ok=0, out=0.
module mod_inv
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] N,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // (x / 2) mod n for odd n: an odd x is made even by adding n first, at
  // WIDTH+1 bits so nothing is lost when n is near 2^WIDTH.
  function automatic logic [WIDTH-1:0] halve_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] n);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, n}) : {1'b0, x};
    return WIDTH'(s >> 1);
  endfunction

  mod_state_e state, state_nxt;

  logic [WIDTH-1:0] u, v, x1, x2, n_r;
  logic [WIDTH-1:0] d12, d21;
  logic [WIDTH-1:0] out_r;
  logic             ok_r, done_r;
  logic             u_one, v_one, term, reject;

  mod_sub #(.WIDTH(WIDTH)) u_sub12 (.a(x1), .b(x2), .n(n_r), .diff(d12));
  mod_sub #(.WIDTH(WIDTH)) u_sub21 (.a(x2), .b(x1), .n(n_r), .diff(d21));

  assign u_one = (u == ONE);
  assign v_one = (v == ONE);
  assign term  = u_one || v_one || (u == '0) || (v == '0);

  // A rejected start loads u=v=0, which the first ITER step turns into a
  // gcd!=1 result (ok=0, out=0). This also keeps A==0 with N==1 from
  // reporting success through the v==1 exit.
`ifdef MOD_INV_ARGCHK_EN
  assign reject = !N[0] || (N < WIDTH'(3)) || (A == '0) || (A >= N);
`else
  assign reject = (A == '0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (term)  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // control and result registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      done_r <= 1'b0;
      ok_r   <= 1'b0;
      out_r  <= '0;
    end else begin
      state  <= state_nxt;
      // done trails the FIN cycle by one clock so it coincides with busy=0
      done_r <= (state == FIN);
      if (state == ITER && term) begin
        if (u_one) begin
          out_r <= x1;
          ok_r  <= 1'b1;
        end else if (v_one) begin
          out_r <= x2;
          ok_r  <= 1'b1;
        end else begin
          out_r <= '0;
          ok_r  <= 1'b0;
        end
      end
    end
  end

  // iteration datapath
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      u   <= reject ? '0 : A;
      v   <= reject ? '0 : N;
      x1  <= ONE;
      x2  <= '0;
      n_r <= N;
    end else if (state == ITER && !term) begin
      if (!u[0]) begin
        u  <= u >> 1;
        x1 <= halve_mod(x1, n_r);
      end else if (!v[0]) begin
        v  <= v >> 1;
        x2 <= halve_mod(x2, n_r);
      end else if (u >= v) begin
        u  <= u - v;
        x1 <= d12;
      end else begin
        v  <= v - u;
        x2 <= d21;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = done_r;
  assign ok   = ok_r;
  assign out  = out_r;

endmodule

// File: tb/tb_mod_inv.sv
module tb_mod_inv;

  localparam int W     = 32;
  localparam int LIMIT = 4 * W + 2;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] n_i;
  logic         busy;
  logic         done;
  logic         ok;
  logic [W-1:0] out_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mod_inv #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .start(start),
    .A    (a_i),
    .N    (n_i),
    .busy (busy),
    .done (done),
    .ok   (ok),
    .out  (out_v)
  );

  // Reference: textbook extended Euclid on 64-bit integers.
  function automatic void ref_inv(input logic [W-1:0] a, input logic [W-1:0] n,
                                  output logic rok, output logic [W-1:0] rout);
    longint r0, r1, t0, t1, q, tmp;
    r0 = n;
    r1 = a;
    t0 = 0;
    t1 = 1;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
    end
    if (a != 0 && r0 == 1) begin
      if (t0 < 0) t0 = t0 + longint'(n);
      rok  = 1'b1;
      rout = W'(t0);
    end else begin
      rok  = 1'b0;
      rout = '0;
    end
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] n);
    a_i   = a;
    n_i   = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat = number of clock edges after the start edge until done is seen
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] n,
                       output logic b_after, output logic g_done, output logic g_busy,
                       output logic g_ok, output logic [W-1:0] g_out, output int lat);
    launch(a, n);
    b_after = busy;
    wait_done(lat);
    g_done = done;
    g_busy = busy;
    g_ok   = ok;
    g_out  = out_v;
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    start = 1'b0;
    a_i   = '0;
    n_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b want 0", ok); end
    checks++; if (out_v !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", out_v); end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [W-1:0] ta [6];
    logic [W-1:0] tn [6];
    logic b1, gd, gb, gok, rok;
    logic [W-1:0] gout, rout;
    int lat;
    ta = '{32'd3, 32'd2,     32'hFFFFFFFE, 32'd6, 32'd1,  32'd17};
    tn = '{32'd7, 32'd65537, 32'hFFFFFFFF, 32'd9, 32'd11, 32'd3233};
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tn[i], b1, gd, gb, gok, gout, lat);
      ref_inv(ta[i], tn[i], rok, rout);
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL vec%0d_busy_after_start: got %b want 1", i, b1); end
      checks++; if (gd !== 1'b1) begin errors++; $display("FAIL vec%0d_done_timeout: no done within %0d clocks", i, LIMIT); end
      checks++; if (gb !== 1'b0) begin errors++; $display("FAIL vec%0d_busy_at_done: got %b want 0", i, gb); end
      checks++; if (gok !== rok) begin errors++; $display("FAIL vec%0d_ok: got %b want %b", i, gok, rok); end
      checks++; if (gout !== rout) begin errors++; $display("FAIL vec%0d_out: got %h want %h", i, gout, rout); end
      if (ta[i] == 32'd1) begin
        checks++; if (lat != 2) begin errors++; $display("FAIL vec%0d_min_latency: got %0d want 2", i, lat); end
      end
    end
  endtask

  task automatic test_done_pulse();
    logic b1, gd, gb, gok, rok;
    logic [W-1:0] gout, rout;
    int lat;
    do_op(32'd3, 32'd7, b1, gd, gb, gok, gout, lat);
    ref_inv(32'd3, 32'd7, rok, rout);
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pulse_done_width: got %b want 0", done); end
    checks++; if (ok !== rok) begin errors++; $display("FAIL pulse_ok_held: got %b want %b", ok, rok); end
    checks++; if (out_v !== rout) begin errors++; $display("FAIL pulse_out_held: got %h want %h", out_v, rout); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, n, gout, rout;
    logic b1, gd, gb, gok, rok;
    int lat;
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 3) begin
        // shared factor 3 -> no inverse
        n = W'(3 * (2 * $urandom_range(1, 20000) + 1));
        a = W'(3 * $urandom_range(1, 1000));
        if (a >= n) a = 32'd3;
      end else begin
        n = $urandom | 32'd1;
        if (n < 32'd3) n = 32'd3;
        a = $urandom % n;
        if (a == '0) a = 32'd1;
      end
      do_op(a, n, b1, gd, gb, gok, gout, lat);
      ref_inv(a, n, rok, rout);
      checks++;
      if (gd !== 1'b1 || gok !== rok || gout !== rout) begin
        errors++;
        $display("FAIL rand%0d A=%h N=%h: got done=%b ok=%b out=%h want done=1 ok=%b out=%h",
                 i, a, n, gd, gok, gout, rok, rout);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic b1, gd, gb, gok, rok;
    logic [W-1:0] gout, rout;
    int lat;
    launch(32'd17, 32'd3233);
    repeat (5) begin @(posedge clk); #1; end
    rstn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ok !== 1'b0 || out_v !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b ok=%b out=%h want all 0", busy, done, ok, out_v);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    do_op(32'd17, 32'd3233, b1, gd, gb, gok, gout, lat);
    ref_inv(32'd17, 32'd3233, rok, rout);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL midreset_rerun_done: got %b want 1", gd); end
    checks++; if (gout !== rout || gok !== rok) begin errors++; $display("FAIL midreset_rerun_out: got ok=%b out=%h want ok=%b out=%h", gok, gout, rok, rout); end
  endtask

  task automatic test_back_to_back();
    logic b1, gd, gb, gok, rok;
    logic [W-1:0] gout, rout;
    int lat;
    do_op(32'd3, 32'd7, b1, gd, gb, gok, gout, lat);
    // next launch starts in the done cycle
    do_op(32'd2, 32'd65537, b1, gd, gb, gok, gout, lat);
    ref_inv(32'd2, 32'd65537, rok, rout);
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b want 1", b1); end
    checks++; if (gd !== 1'b1 || gout !== rout || gok !== rok) begin errors++; $display("FAIL b2b_result: got done=%b ok=%b out=%h want ok=%b out=%h", gd, gok, gout, rok, rout); end
    // start pulse while busy must not resample operands
    launch(32'd17, 32'd3233);
    @(posedge clk); #1;
    a_i = 32'd5;
    n_i = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_ignore_busy: got %b want 1", busy); end
    wait_done(lat);
    ref_inv(32'd17, 32'd3233, rok, rout);
    checks++; if (done !== 1'b1 || out_v !== rout || ok !== rok) begin errors++; $display("FAIL busy_ignore_result: got done=%b ok=%b out=%h want ok=%b out=%h", done, ok, out_v, rok, rout); end
  endtask

  task automatic test_illegal();
    logic b1, gd, gb, gok;
    logic [W-1:0] gout;
    int lat;
`ifdef MOD_INV_ARGCHK_EN
    do_op(32'd5, 32'd10, b1, gd, gb, gok, gout, lat);
    checks++; if (gd !== 1'b1 || lat != 2) begin errors++; $display("FAIL argchk_even_latency: got done=%b lat=%0d want done=1 lat=2", gd, lat); end
    checks++; if (gok !== 1'b0 || gout !== '0) begin errors++; $display("FAIL argchk_even_result: got ok=%b out=%h want 0/0", gok, gout); end
    do_op(32'd12, 32'd11, b1, gd, gb, gok, gout, lat);
    checks++; if (gd !== 1'b1 || lat != 2 || gok !== 1'b0 || gout !== '0) begin errors++; $display("FAIL argchk_a_ge_n: got done=%b lat=%0d ok=%b out=%h want 1/2/0/0", gd, lat, gok, gout); end
`else
    do_op(32'd0, 32'd11, b1, gd, gb, gok, gout, lat);
    checks++; if (gd !== 1'b1 || gok !== 1'b0) begin errors++; $display("FAIL a_zero: got done=%b ok=%b want done=1 ok=0", gd, gok); end
    do_op(32'd7, 32'd10, b1, gd, gb, gok, gout, lat);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL even_n_terminates: got done=%b want 1", gd); end
`endif
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_done_pulse();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
